// File: rtl/regset_master_if.sv
// Bus bundle for regset_master: request/response port toward the control
// logic plus the Address/Data_in/RW/Data_out port toward the register set.
interface regset_master_if #(
  parameter int DW = 4,
  parameter int AW = 3
);
  // Request side
  logic          Req_valid;
  logic          Req_ready;
  logic          Req_rw;
  logic [AW-1:0] Req_addr;
  logic [DW-1:0] Req_data;
  // Response side
  logic          Rsp_valid;
  logic [DW-1:0] Rsp_data;
  logic          Rsp_err;
  // Register-set side
  logic [AW-1:0] Reg_addr;
  logic [DW-1:0] Reg_wdata;
  logic          Reg_rw;
  logic [DW-1:0] Reg_rdata;
  // Status
  logic          Busy;

  modport master (
    input  Req_valid, Req_rw, Req_addr, Req_data, Reg_rdata,
    output Req_ready, Rsp_valid, Rsp_data, Rsp_err,
           Reg_addr, Reg_wdata, Reg_rw, Busy
  );

  modport slave (
    output Req_valid, Req_rw, Req_addr, Req_data, Reg_rdata,
    input  Req_ready, Rsp_valid, Rsp_data, Rsp_err,
           Reg_addr, Reg_wdata, Reg_rw, Busy
  );
endinterface

// File: rtl/regset_master.sv
// regset_master: turns single valid/ready requests into register-set
// write/read cycles and returns a one-cycle response.
// Optional macro READBACK_VERIFY_EN: after each write, read the same address
// back and report Rsp_err when it differs from the written data.
module regset_master #(
  parameter int DW     = 4,
  parameter int AW     = 3,
  parameter int RD_LAT = 1
) (
  input logic              Clk,
  input logic              Rst_n,
  regset_master_if.master  bus
);

  localparam int           CW     = 4;
  localparam logic [CW-1:0] C_LAST = CW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
`ifdef READBACK_VERIFY_EN
    S_VERIFY = 3'd3,
`endif
    S_RESP   = 3'd4
  } state_t;

  state_t        r_state,     w_state_nxt;
  logic [CW-1:0] r_cnt,       w_cnt_nxt;
  logic          r_ready,     w_ready_nxt;
  logic          r_reg_rw,    w_reg_rw_nxt;
  logic [AW-1:0] r_reg_addr,  w_reg_addr_nxt;
  logic [DW-1:0] r_reg_wdata, w_reg_wdata_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0] r_rsp_data,  w_rsp_data_nxt;
  logic          r_rsp_err,   w_rsp_err_nxt;

  // State and registered outputs; async reset forces Reg_rw low at once
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_reg_rw    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready     <= w_ready_nxt;
      r_reg_rw    <= w_reg_rw_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next state plus next values of every registered output, so each output
  // already holds its value for the state being entered
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_reg_rw_nxt    = 1'b0;
    w_reg_addr_nxt  = r_reg_addr;
    w_reg_wdata_nxt = r_reg_wdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        if (bus.Req_valid) begin
          w_reg_addr_nxt  = bus.Req_addr;
          w_reg_wdata_nxt = bus.Req_data;
          w_cnt_nxt       = '0;
          if (bus.Req_rw) begin
            w_state_nxt  = S_WRITE;
            w_reg_rw_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_READ;
          end
        end
      end

      S_WRITE: begin
`ifdef READBACK_VERIFY_EN
        w_state_nxt = S_VERIFY;
        w_cnt_nxt   = '0;
`else
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = r_reg_wdata;
        w_rsp_err_nxt   = 1'b0;
`endif
      end

      S_READ: begin
        if (r_cnt == C_LAST) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = bus.Reg_rdata;
          w_rsp_err_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

`ifdef READBACK_VERIFY_EN
      S_VERIFY: begin
        if (r_cnt == C_LAST) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = bus.Reg_rdata;
          w_rsp_err_nxt   = (bus.Reg_rdata != r_reg_wdata);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  assign bus.Req_ready = r_ready;
  assign bus.Busy      = ~r_ready;
  assign bus.Reg_rw    = r_reg_rw;
  assign bus.Reg_addr  = r_reg_addr;
  assign bus.Reg_wdata = r_reg_wdata;
  assign bus.Rsp_valid = r_rsp_valid;
  assign bus.Rsp_data  = r_rsp_data;
  assign bus.Rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_regset_master.sv
// Testbench for regset_master with a behavioural 8x4 register set.
// With READBACK_VERIFY_EN, register 3 has bit0 stuck at 0 on read.
module tb_regset_master;

  localparam int DW     = 4;
  localparam int AW     = 3;
  localparam int RD_LAT = 1;
`ifdef READBACK_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int LAT_W = VERIFY ? RD_LAT + 2 : 2;
  localparam int LAT_R = RD_LAT + 1;
  localparam int PER_W = LAT_W + 1;
  localparam int PER_R = RD_LAT + 2;

  logic Clk;
  logic Rst_n;

  regset_master_if #(.DW(DW), .AW(AW)) bus ();

  regset_master #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural register set
  logic [DW-1:0] mem [0:7];
  always @(posedge Clk) begin
    if (bus.Reg_rw) mem[bus.Reg_addr] <= bus.Reg_wdata;
  end

  always_comb begin
    bus.Reg_rdata = mem[bus.Reg_addr];
`ifdef READBACK_VERIFY_EN
    if (bus.Reg_addr == 3'd3) bus.Reg_rdata[0] = 1'b0;
`endif
  end

  int cyc;
  int rw_hi;
  int rsp_cnt;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (bus.Reg_rw)    rw_hi   <= rw_hi + 1;
    if (bus.Rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  int nerr;
  int nchk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Value the register set returns for address a holding d
  function automatic logic [3:0] rb(input logic [2:0] a, input logic [3:0] d);
    logic [3:0] v;
    v = d;
    if (VERIFY && a == 3'd3) v[0] = 1'b0;
    return v;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.Req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  // Issue one request (called at a negedge), return response and timing.
  // scramble: after the accept edge drop Req_valid and change addr/data.
  task automatic txn(input logic rw, input logic [2:0] a, input logic [3:0] d,
                     input bit scramble, output logic [3:0] rd, output logic re,
                     output int lat, output int acc);
    bit ok;
    bus.Req_valid = 1'b1;
    bus.Req_rw    = rw;
    bus.Req_addr  = a;
    bus.Req_data  = d;
    rd  = '0;
    re  = 1'b0;
    lat = -1;
    acc = -1;
    wait_ready(ok);
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      acc = cyc + 1;
      if (scramble) begin
        @(posedge Clk);
        #1;
        bus.Req_valid = 1'b0;
        bus.Req_addr  = a ^ 3'd4;
        bus.Req_data  = d ^ 4'h5;
      end
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge Clk);
        if (bus.Rsp_valid) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        chk("rsp_timeout", 32'd0, 32'd1);
      end else begin
        lat = cyc + 1 - acc;
        rd  = bus.Rsp_data;
        re  = bus.Rsp_err;
        @(negedge Clk);
        chk("rsp_pulse_width", 32'(bus.Rsp_valid), 32'd0);
      end
    end
  endtask

  typedef struct {
    logic       rw;
    logic [2:0] addr;
    logic [3:0] data;
    logic [3:0] exp_data;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [3:0] rd;
    logic       re;
    int         lat, acc, prev, r0, rsp0;
    bit         ok;

    // Writes 0..7, then reads 7 down to 0
    for (int i = 0; i < 8; i++) begin
      vecs[i].rw       = 1'b1;
      vecs[i].addr     = 3'(i);
      vecs[i].data     = 4'(i);
      vecs[i].exp_data = VERIFY ? rb(3'(i), 4'(i)) : 4'(i);
      vecs[i].exp_err  = VERIFY && (rb(3'(i), 4'(i)) != 4'(i));
      vecs[i].exp_lat  = LAT_W;
    end
    for (int i = 8; i < 16; i++) begin
      vecs[i].rw       = 1'b0;
      vecs[i].addr     = 3'(15 - i);
      vecs[i].data     = 4'hF;
      vecs[i].exp_data = rb(3'(15 - i), 4'(15 - i));
      vecs[i].exp_err  = 1'b0;
      vecs[i].exp_lat  = LAT_R;
    end

    Rst_n         = 1'b1;
    bus.Req_valid = 1'b0;
    bus.Req_rw    = 1'b0;
    bus.Req_addr  = '0;
    bus.Req_data  = '0;

    // Asynchronous reset before any clock edge
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_ready",     32'(bus.Req_ready), 32'd1);
    chk("rst_busy",      32'(bus.Busy),      32'd0);
    chk("rst_reg_rw",    32'(bus.Reg_rw),    32'd0);
    chk("rst_rsp_valid", 32'(bus.Rsp_valid), 32'd0);
    chk("rst_reg_addr",  32'(bus.Reg_addr),  32'd0);
    chk("rst_reg_wdata", 32'(bus.Reg_wdata), 32'd0);
    chk("rst_rsp_data",  32'(bus.Rsp_data),  32'd0);
    chk("rst_rsp_err",   32'(bus.Rsp_err),   32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Table: back-to-back writes then reads with Req_valid held
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      r0 = rw_hi;
      txn(vecs[i].rw, vecs[i].addr, vecs[i].data, 1'b0, rd, re, lat, acc);
      chk($sformatf("v%0d_data", i), 32'(rd),  32'(vecs[i].exp_data));
      chk($sformatf("v%0d_err", i),  32'(re),  32'(vecs[i].exp_err));
      chk($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rw_pulses", i), 32'(rw_hi - r0), vecs[i].rw ? 32'd1 : 32'd0);
      if (i > 0)
        chk($sformatf("v%0d_spacing", i), 32'(acc - prev),
            vecs[i-1].rw ? 32'(PER_W) : 32'(PER_R));
      prev = acc;
    end
    bus.Req_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("mem%0d", i), 32'(mem[i]), 32'(i));

    // Reset during WRITE to addr 5: aborted, no response, register untouched
    @(negedge Clk);
    rsp0 = rsp_cnt;
    r0   = rw_hi;
    bus.Req_valid = 1'b1;
    bus.Req_rw    = 1'b1;
    bus.Req_addr  = 3'd5;
    bus.Req_data  = 4'hA;
    wait_ready(ok);
    chk("t4_accept", 32'(ok), 32'd1);
    @(posedge Clk);
    #1;
    bus.Req_valid = 1'b0;
    chk("t4_rw_in_write", 32'(bus.Reg_rw), 32'd1);
    chk("t4_busy",        32'(bus.Busy),   32'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("t4_rw_async_drop", 32'(bus.Reg_rw),    32'd0);
    chk("t4_ready",         32'(bus.Req_ready), 32'd1);
    chk("t4_rsp_valid",     32'(bus.Rsp_valid), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("t4_no_rsp",   32'(rsp_cnt - rsp0), 32'd0);
    chk("t4_mem5",     32'(mem[5]),         32'd5);
    txn(1'b0, 3'd5, 4'h0, 1'b0, rd, re, lat, acc);
    bus.Req_valid = 1'b0;
    chk("t4_read5",     32'(rd),  32'd5);
    chk("t4_read5_lat", 32'(lat), 32'(LAT_R));

    // Request fields changed while busy: only accept-edge values used
    txn(1'b1, 3'd2, 4'h9, 1'b1, rd, re, lat, acc);
    bus.Req_valid = 1'b0;
    chk("t5_rsp_data", 32'(rd),     32'h9);
    chk("t5_rsp_err",  32'(re),     32'd0);
    chk("t5_lat",      32'(lat),    32'(LAT_W));
    chk("t5_mem2",     32'(mem[2]), 32'h9);
    chk("t5_mem6",     32'(mem[6]), 32'h6);
    txn(1'b0, 3'd6, 4'h0, 1'b0, rd, re, lat, acc);
    bus.Req_valid = 1'b0;
    chk("t5_read6", 32'(rd), 32'(rb(3'd6, 4'h6)));

    // Write to the stuck register and to a healthy one
    txn(1'b1, 3'd3, 4'hF, 1'b0, rd, re, lat, acc);
    bus.Req_valid = 1'b0;
    chk("t6_a3_data", 32'(rd),  VERIFY ? 32'hE : 32'hF);
    chk("t6_a3_err",  32'(re),  VERIFY ? 32'd1 : 32'd0);
    chk("t6_a3_lat",  32'(lat), 32'(LAT_W));
    txn(1'b1, 3'd2, 4'h5, 1'b0, rd, re, lat, acc);
    bus.Req_valid = 1'b0;
    chk("t6_a2_data", 32'(rd),  32'h5);
    chk("t6_a2_err",  32'(re),  32'd0);
    chk("t6_a2_lat",  32'(lat), 32'(LAT_W));
    chk("t6_mem2",    32'(mem[2]), 32'h5);

    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
